arbitro_somador: RTL

- Round-robin arbiter and sequencer that shares one 44-bit adder/accumulator datapath among 4 requesters.
- Each requester owns a private 44-bit running total.
- A granted transaction adds E1+E2, then adds that sum into the requester's own accumulator.
- The block replaces per-client copies of the accumulating adder in the Trab3 datapath.

---
 rtl/arbitro_somador_if.sv | 29 ++
 rtl/arbitro_somador.sv | 93 +++++++++
 2 files changed

// File: rtl/arbitro_somador_if.sv
// Request/response bundle between the four requesters and the shared adder/accumulator.
interface arbitro_somador_if #(
  parameter int unsigned WIDTH = 44,
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = 2;

  logic                     hold;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_clear;
  logic [N_REQ*WIDTH-1:0]   req_e1;
  logic [N_REQ*WIDTH-1:0]   req_e2;
  logic [N_REQ-1:0]         req_ready;
  logic                     res_valid;
  logic [ID_W-1:0]          res_id;
  logic [WIDTH-1:0]         res_sum;
  logic                     res_ovf;
  logic                     busy;

  modport master (
    output hold, req_valid, req_clear, req_e1, req_e2,
    input  req_ready, res_valid, res_id, res_sum, res_ovf, busy
  );

  modport slave (
    input  hold, req_valid, req_clear, req_e1, req_e2,
    output req_ready, res_valid, res_id, res_sum, res_ovf, busy
  );
endinterface

// File: rtl/arbitro_somador.sv
// Round-robin arbiter sharing one two-stage E1+E2 adder and per-requester accumulators
// among four requesters.
module arbitro_somador #(
  parameter int unsigned WIDTH = 44,
  parameter int unsigned N_REQ = 4
) (
  input  logic               clock,
  input  logic               reset,
  arbitro_somador_if.slave   bus
);
  localparam int unsigned ID_W = 2;

  logic [ID_W-1:0]  ptr;
  logic             s1_valid;
  logic [ID_W-1:0]  s1_id;
  logic             s1_clr;
  logic [WIDTH-1:0] s1_sum;
  logic             s1_c;
  logic [WIDTH-1:0] acc [N_REQ];

  logic [N_REQ-1:0] grant_c;
  logic [ID_W-1:0]  grant_id_c;
  logic [ID_W-1:0]  idx_c;
  logic             grant_any_c;
  logic [WIDTH-1:0] e1_c;
  logic [WIDTH-1:0] e2_c;
  logic [WIDTH-1:0] base_c;
  logic [WIDTH:0]   sum1_c;
  logic [WIDTH:0]   sum2_c;

  // Search starts one past the last grant and wraps back to it last.
  always_comb begin
    grant_c     = '0;
    grant_id_c  = ptr;
    grant_any_c = 1'b0;
    idx_c       = ptr;
    if (!reset && !bus.hold) begin
      for (int k = 1; k <= int'(N_REQ); k++) begin
        idx_c = ptr + ID_W'(k);
        if (!grant_any_c && bus.req_valid[idx_c]) begin
          grant_any_c = 1'b1;
          grant_id_c  = idx_c;
        end
      end
    end
    if (grant_any_c) grant_c[grant_id_c] = 1'b1;
  end

  assign bus.req_ready = grant_c;

  // Stage 2 reads the accumulator at its own edge, so back-to-back updates chain.
  always_comb begin
    e1_c   = bus.req_e1[32'(grant_id_c) * WIDTH +: WIDTH];
    e2_c   = bus.req_e2[32'(grant_id_c) * WIDTH +: WIDTH];
    sum1_c = {1'b0, e1_c} + {1'b0, e2_c};
    base_c = s1_clr ? '0 : acc[s1_id];
    sum2_c = {1'b0, base_c} + {1'b0, s1_sum};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr           <= ID_W'(N_REQ - 1);
      s1_valid      <= 1'b0;
      s1_id         <= '0;
      s1_clr        <= 1'b0;
      s1_sum        <= '0;
      s1_c          <= 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) acc[i] <= '0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= '0;
      bus.res_sum   <= '0;
      bus.res_ovf   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      s1_valid      <= grant_any_c;
      bus.res_valid <= s1_valid;
      bus.busy      <= grant_any_c | s1_valid;
      if (grant_any_c) begin
        ptr    <= grant_id_c;
        s1_id  <= grant_id_c;
        s1_clr <= bus.req_clear[grant_id_c];
        s1_sum <= sum1_c[WIDTH-1:0];
        s1_c   <= sum1_c[WIDTH];
      end
      if (s1_valid) begin
        acc[s1_id]  <= sum2_c[WIDTH-1:0];
        bus.res_sum <= sum2_c[WIDTH-1:0];
        bus.res_id  <= s1_id;
        bus.res_ovf <= s1_c | sum2_c[WIDTH];
      end
    end
  end
endmodule
